pcs_40g_tx_framer: RTL and testbench
====================================

# pcs_40g_tx_framer

Upstream neighbour of the 40G PCS transmit path. It converts a MAC-side 256-bit frame stream (valid/ready, byte keep, last, error) into the per-lane XGMII-style control/data view the 40G PCS transmit block consumes: four 64-bit blocks per cycle, each flagged ctrl/idle/start/term/err. The block inserts the start block with preamble/SFD, shifts the payload by one lane, places the terminate block with its byte count, and enforces inter-frame idle. It stalls on the PCS `ready_o` (gearbox-full and alignment-marker slots).

## Interface
- LANE_N, 4, blocks per cycle
- DATA_W, 64, bits per lane
- KEEP_W, DATA_W/8, keep bits per lane
- XGMII_DATA_W, LANE_N*DATA_W, stream data width (256)
- XGMII_KEEP_W, LANE_N*KEEP_W, stream keep width (32)

- clk  in  1  clock; single clock domain
- nreset  in  1  synchronous, active-low reset
- s_valid_i  in  1  MAC beat valid
- s_ready_o  out  1  beat accepted when s_valid_i & s_ready_o
- s_data_i  in  256  payload, byte 0 = bits [7:0], starts at destination MAC address
- s_keep_i  in  32  contiguous from bit 0; all ones except on last beat
- s_last_i  in  1  last beat of frame
- s_err_i  in  1  frame error, sampled with s_last_i
- pcs_ready_i  in  1  PCS consumes presented outputs this cycle
- ctrl_v_o, idle_v_o, start_v_o, term_v_o, err_v_o  out  4  per-lane block flags
- data_o  out  256  per-lane block data
- keep_o  out  32  per-lane keep

## Operation
- Lane kinds: data (all flags 0, keep 0xFF); idle (ctrl+idle, keep 0x00, data 0); start (ctrl+start, data 0xD555555555555555, keep 0xFF); term (ctrl+term, keep = (1<<m)-1 for m data bytes ahead of /T/); error (ctrl+err, keep 0x00).
- Output lane k (k=1..3) carries input lane k-1 of the current beat; lane 0 carries the 8-byte residual (input lane 3) of the previous beat, or the start block in a frame's first cycle.
- FSM states: IDLE, DATA, TAIL, GAP, plus DROP (macro only).
- IDLE: outputs all idle. If s_valid_i & pcs_ready_i, accept the beat and emit start + lanes 1-3. Go to DATA, or handle termination if s_last_i is set.
- DATA: on each pcs_ready_i, accept the beat and emit residual + lanes 1-3.
- Termination on the last beat with N valid bytes (1..32): let E=N+8, t=E/8, m=E%8.
  - t≤3: term is on lane t with keep m; lanes >t are idle; go to GAP.
  - t=4: go to TAIL; TAIL emits term on lane 0 with keep m, then idle.
  - t=5: TAIL emits residual data on lane 0, term on lane 1 with keep 0, then idle.
  - TAIL goes to GAP.
- s_err_i=1 with s_last_i: the term lane becomes an error lane. Placement is identical.
- GAP: emit one all-idle cycle, then go to IDLE. This gives ≥32 idle bytes, which exceeds the 12-byte IFG.
- Underrun: in DATA with pcs_ready_i=1 and s_valid_i=0, emit error on all 4 lanes. The residual and state are held. See Configuration.
- s_ready_o = pcs_ready_i & state∈{IDLE,DATA} (also DROP when enabled). It is 0 while nreset=0.

## Timing
- All flag/data/keep outputs are registered. An edge with pcs_ready_i=1 loads the next presented value. An edge with pcs_ready_i=0 holds all outputs, state and residual unchanged.
- Latency: an accepted beat appears on the outputs the next cycle. Its lane 3 appears one further consumed cycle later.
- Reset values: ctrl_v_o=idle_v_o=4'hF; start_v_o, term_v_o, err_v_o, data_o and keep_o are 0; state IDLE; residual 0.
- Reset mid-frame: the frame is dropped; the next presented cycle is all idle.
- Single-beat frame: start and term may share one cycle. With N=1, lanes are start, term(keep 0x01), idle, idle.
- Start always lands on lane 0. No frame starts in a cycle that carries a term.

## Configuration
- PCS_TX_UNDERRUN_ABORT_EN
  - Defined: an underrun emits one all-error cycle, then the FSM enters DROP. DROP accepts and discards beats (s_ready_o=pcs_ready_i) and outputs idle until a beat with s_last_i is accepted, then goes to GAP.
  - Undefined: an underrun emits all-error cycles for as long as it lasts. The frame then resumes in DATA with the residual intact.

## Test plan
- 64-byte frame: 2 full beats, N=32 on the last, pcs_ready_i=1. Expect start,D,D,D / D,D,D,D / D,term(keep 0x00),idle,idle / all-idle GAP. s_ready_o=0 during TAIL and GAP.
- Single beat with N=16. Expect start,D,D,term(keep 0x00). Next cycle all idle.
- Last beat with N=28. Expect TAIL lane 0 term with keep 0x0F, lanes 1-3 idle.
- Drive pcs_ready_i low for 3 cycles mid-frame. Expect outputs and s_ready_o frozen, with no beat lost or duplicated.
- s_err_i=1 on a last beat with N=8. Expect lane 2 err_v=1, ctrl_v=1, term_v=0.
- Underrun with s_valid_i=0 for 1 cycle. Expect err_v_o=4'hF. With the macro: DROP until last, then GAP. Without it: the residual appears on lane 0 of the next cycle.

Source files
------------

// File: rtl/pcs_40g_tx_framer_if.sv
// MAC-side 256-bit frame stream into the 40G PCS transmit framer.
// master = MAC source, slave = framer.
interface pcs_40g_tx_framer_if #(
  parameter int unsigned XGMII_DATA_W = 256,
  parameter int unsigned XGMII_KEEP_W = 32
);
  logic                    s_valid_i;
  logic                    s_ready_o;
  logic [XGMII_DATA_W-1:0] s_data_i;
  logic [XGMII_KEEP_W-1:0] s_keep_i;
  logic                    s_last_i;
  logic                    s_err_i;

  modport master (
    output s_valid_i, s_data_i, s_keep_i, s_last_i, s_err_i,
    input  s_ready_o
  );

  modport slave (
    input  s_valid_i, s_data_i, s_keep_i, s_last_i, s_err_i,
    output s_ready_o
  );
endinterface

// File: rtl/pcs_40g_tx_framer.sv
// Frames a MAC stream into per-lane start/data/term/idle blocks for the 40G PCS TX path.
// Optional PCS_TX_UNDERRUN_ABORT_EN: an underrun aborts the frame and drops the rest of it.
module pcs_40g_tx_framer #(
  parameter int unsigned LANE_N       = 4,
  parameter int unsigned DATA_W       = 64,
  parameter int unsigned KEEP_W       = DATA_W / 8,
  parameter int unsigned XGMII_DATA_W = LANE_N * DATA_W,
  parameter int unsigned XGMII_KEEP_W = LANE_N * KEEP_W
) (
  input  logic                    clk,
  input  logic                    nreset,
  pcs_40g_tx_framer_if.slave      s,
  input  logic                    pcs_ready_i,
  output logic [LANE_N-1:0]       ctrl_v_o,
  output logic [LANE_N-1:0]       idle_v_o,
  output logic [LANE_N-1:0]       start_v_o,
  output logic [LANE_N-1:0]       term_v_o,
  output logic [LANE_N-1:0]       err_v_o,
  output logic [XGMII_DATA_W-1:0] data_o,
  output logic [XGMII_KEEP_W-1:0] keep_o
);
  localparam int unsigned       MW         = (KEEP_W > 1) ? $clog2(KEEP_W) : 1;
  localparam logic [DATA_W-1:0] START_WORD = DATA_W'(64'hD555_5555_5555_5555);

`ifdef PCS_TX_UNDERRUN_ABORT_EN
  typedef enum logic [2:0] {ST_IDLE, ST_DATA, ST_TAIL, ST_GAP, ST_DROP} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_TAIL, ST_GAP} state_t;
`endif
  typedef enum logic [2:0] {K_DATA, K_IDLE, K_START, K_TERM, K_ERR} kind_t;

  state_t            state, nxt_state;
  logic [DATA_W-1:0] residual, nxt_residual;
  logic              tail_ovf, nxt_tail_ovf;
  logic [MW-1:0]     tail_m, nxt_tail_m;
  logic              tail_err, nxt_tail_err;
  logic              accepts;

  kind_t             kind  [LANE_N];
  logic [DATA_W-1:0] ldata [LANE_N];
  logic [KEEP_W-1:0] lkeep [LANE_N];

  logic [LANE_N-1:0]       n_ctrl, n_idle, n_start, n_term, n_err;
  logic [XGMII_DATA_W-1:0] n_data;
  logic [XGMII_KEEP_W-1:0] n_keep;
  int unsigned             nb, t_lane, m_bytes;

  function automatic logic [KEEP_W-1:0] low_keep(input int unsigned m);
    low_keep = '0;
    for (int unsigned i = 0; i < KEEP_W; i++) low_keep[i] = (i < m);
  endfunction

  function automatic logic [DATA_W-1:0] low_bytes(input logic [DATA_W-1:0] d, input int unsigned m);
    low_bytes = '0;
    for (int unsigned i = 0; i < KEEP_W; i++)
      if (i < m) low_bytes[i*8 +: 8] = d[i*8 +: 8];
  endfunction

  always_comb begin
    accepts = (state == ST_IDLE) || (state == ST_DATA);
`ifdef PCS_TX_UNDERRUN_ABORT_EN
    if (state == ST_DROP) accepts = 1'b1;
`endif
  end

  assign s.s_ready_o = nreset & pcs_ready_i & accepts;

  always_comb begin
    nxt_state    = state;
    nxt_residual = residual;
    nxt_tail_ovf = tail_ovf;
    nxt_tail_m   = tail_m;
    nxt_tail_err = tail_err;
    for (int unsigned k = 0; k < LANE_N; k++) begin
      kind[k]  = K_IDLE;
      ldata[k] = '0;
      lkeep[k] = '0;
    end

    // Frame end position: /T/ sits t lanes in, counting the leading start/residual lane.
    nb = 0;
    for (int unsigned i = 0; i < XGMII_KEEP_W; i++) if (s.s_keep_i[i]) nb++;
    t_lane  = (nb + KEEP_W) / KEEP_W;
    m_bytes = (nb + KEEP_W) % KEEP_W;

    case (state)
      ST_IDLE, ST_DATA: begin
        if (s.s_valid_i) begin
          kind[0]  = (state == ST_IDLE) ? K_START : K_DATA;
          ldata[0] = residual;
          for (int unsigned k = 1; k < LANE_N; k++) begin
            kind[k]  = K_DATA;
            ldata[k] = s.s_data_i[(k-1)*DATA_W +: DATA_W];
          end
          nxt_residual = s.s_data_i[(LANE_N-1)*DATA_W +: DATA_W];
          nxt_state    = ST_DATA;
          if (s.s_last_i) begin
            if (t_lane < LANE_N) begin
              for (int unsigned k = 1; k < LANE_N; k++) begin
                if (k == t_lane) begin
                  kind[k]  = s.s_err_i ? K_ERR : K_TERM;
                  ldata[k] = s.s_err_i ? '0 : low_bytes(ldata[k], m_bytes);
                  lkeep[k] = s.s_err_i ? '0 : low_keep(m_bytes);
                end else if (k > t_lane) begin
                  kind[k]  = K_IDLE;
                  ldata[k] = '0;
                end
              end
              nxt_state = ST_GAP;
            end else begin
              nxt_state    = ST_TAIL;
              nxt_tail_ovf = (t_lane > LANE_N);
              nxt_tail_m   = MW'(m_bytes);
              nxt_tail_err = s.s_err_i;
            end
          end
        end else if (state == ST_DATA) begin
          for (int unsigned k = 0; k < LANE_N; k++) kind[k] = K_ERR;
`ifdef PCS_TX_UNDERRUN_ABORT_EN
          nxt_state = ST_DROP;
`endif
        end
      end
      ST_TAIL: begin
        if (tail_ovf) begin
          kind[0]  = K_DATA;
          ldata[0] = residual;
          kind[1]  = tail_err ? K_ERR : K_TERM;
        end else begin
          kind[0] = tail_err ? K_ERR : K_TERM;
          if (!tail_err) begin
            ldata[0] = low_bytes(residual, 32'(tail_m));
            lkeep[0] = low_keep(32'(tail_m));
          end
        end
        nxt_state = ST_GAP;
      end
      ST_GAP: nxt_state = ST_IDLE;
`ifdef PCS_TX_UNDERRUN_ABORT_EN
      ST_DROP: if (s.s_valid_i && s.s_last_i) nxt_state = ST_GAP;
`endif
      default: nxt_state = ST_IDLE;
    endcase

    n_ctrl  = '0;
    n_idle  = '0;
    n_start = '0;
    n_term  = '0;
    n_err   = '0;
    n_data  = '0;
    n_keep  = '0;
    for (int unsigned k = 0; k < LANE_N; k++) begin
      n_ctrl[k]  = (kind[k] != K_DATA);
      n_idle[k]  = (kind[k] == K_IDLE);
      n_start[k] = (kind[k] == K_START);
      n_term[k]  = (kind[k] == K_TERM);
      n_err[k]   = (kind[k] == K_ERR);
      case (kind[k])
        K_START: n_data[k*DATA_W +: DATA_W] = START_WORD;
        K_DATA,
        K_TERM:  n_data[k*DATA_W +: DATA_W] = ldata[k];
        default: n_data[k*DATA_W +: DATA_W] = '0;
      endcase
      case (kind[k])
        K_START,
        K_DATA:  n_keep[k*KEEP_W +: KEEP_W] = '1;
        K_TERM:  n_keep[k*KEEP_W +: KEEP_W] = lkeep[k];
        default: n_keep[k*KEEP_W +: KEEP_W] = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state     <= ST_IDLE;
      residual  <= '0;
      tail_ovf  <= 1'b0;
      tail_m    <= '0;
      tail_err  <= 1'b0;
      ctrl_v_o  <= '1;
      idle_v_o  <= '1;
      start_v_o <= '0;
      term_v_o  <= '0;
      err_v_o   <= '0;
      data_o    <= '0;
      keep_o    <= '0;
    end else if (pcs_ready_i) begin
      state     <= nxt_state;
      residual  <= nxt_residual;
      tail_ovf  <= nxt_tail_ovf;
      tail_m    <= nxt_tail_m;
      tail_err  <= nxt_tail_err;
      ctrl_v_o  <= n_ctrl;
      idle_v_o  <= n_idle;
      start_v_o <= n_start;
      term_v_o  <= n_term;
      err_v_o   <= n_err;
      data_o    <= n_data;
      keep_o    <= n_keep;
    end
  end
endmodule

// File: tb/tb_pcs_40g_tx_framer.sv
// Randomized bench for pcs_40g_tx_framer against a lane-stream reference model.
// Frames become a queue of 8-byte lanes (start, payload, /T/, idle pad, gap) drained four per consumed cycle.
module tb_pcs_40g_tx_framer;
  localparam logic [63:0] START_WORD = 64'hD555_5555_5555_5555;

  typedef enum {L_DATA, L_IDLE, L_START, L_TERM, L_ERR} lkind_t;
  typedef struct {
    lkind_t      kind;
    logic [63:0] data;
    logic [7:0]  keep;
  } lane_t;
  typedef struct {
    logic [255:0] data;
    logic [31:0]  keep;
    bit           last;
    bit           err;
    int unsigned  pre;
  } beat_t;

  logic         clk = 1'b0;
  logic         nreset = 1'b0;
  logic         pcs_ready_i = 1'b0;
  logic [3:0]   ctrl_v_o, idle_v_o, start_v_o, term_v_o, err_v_o;
  logic [255:0] data_o;
  logic [31:0]  keep_o;

  pcs_40g_tx_framer_if sif ();

  pcs_40g_tx_framer dut (
    .clk         (clk),
    .nreset      (nreset),
    .s           (sif),
    .pcs_ready_i (pcs_ready_i),
    .ctrl_v_o    (ctrl_v_o),
    .idle_v_o    (idle_v_o),
    .start_v_o   (start_v_o),
    .term_v_o    (term_v_o),
    .err_v_o     (err_v_o),
    .data_o      (data_o),
    .keep_o      (keep_o)
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned failures = 0;
  lane_t       q[$];
  lane_t       cur[4];
  bit          in_frame = 1'b0;
  bit          dropping = 1'b0;
  beat_t       src[$];
  int unsigned stall_left = 0;
  bit          rand_rdy = 1'b0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic lane_t mk(input lkind_t k, input logic [63:0] d, input logic [7:0] kp);
    lane_t l;
    l.kind = k;
    l.data = d;
    l.keep = kp;
    return l;
  endfunction

  task automatic set_all(input lkind_t k);
    for (int i = 0; i < 4; i++) cur[i] = mk(k, '0, '0);
  endtask

  task automatic pop4();
    for (int i = 0; i < 4; i++) cur[i] = q.pop_front();
  endtask

  task automatic push_beat(input beat_t b);
    int unsigned n, nf, rem;
    logic [63:0] d;
    logic [7:0]  kp;
    n   = $countones(b.keep);
    nf  = n / 8;
    rem = n % 8;
    for (int unsigned i = 0; i < nf; i++) q.push_back(mk(L_DATA, b.data[i*64 +: 64], 8'hFF));
    if (b.last) begin
      if (b.err) begin
        q.push_back(mk(L_ERR, '0, '0));
      end else begin
        d  = '0;
        kp = '0;
        for (int unsigned j = 0; j < rem; j++) begin
          d[j*8 +: 8] = b.data[nf*64 + j*8 +: 8];
          kp[j]       = 1'b1;
        end
        q.push_back(mk(L_TERM, d, kp));
      end
      while (q.size() % 4 != 0) q.push_back(mk(L_IDLE, '0, '0));
      repeat (4) q.push_back(mk(L_IDLE, '0, '0));
    end
  endtask

  task automatic model_step(input bit valid, input bit acc, input beat_t b);
    if (dropping) begin
      set_all(L_IDLE);
      if (acc && b.last) begin
        dropping = 1'b0;
        repeat (4) q.push_back(mk(L_IDLE, '0, '0));
      end
    end else if (!in_frame && q.size() != 0) begin
      pop4();
    end else if (in_frame && !valid) begin
      set_all(L_ERR);
`ifdef PCS_TX_UNDERRUN_ABORT_EN
      in_frame = 1'b0;
      dropping = 1'b1;
      q.delete();
`endif
    end else if (acc) begin
      if (!in_frame) q.push_back(mk(L_START, START_WORD, 8'hFF));
      push_beat(b);
      in_frame = !b.last;
      pop4();
    end else begin
      set_all(L_IDLE);
    end
  endtask

  task automatic tick();
    logic         exp_rdy;
    bit           valid, acc;
    beat_t        b;
    logic [3:0]   ec, ei, es, et, ee;
    logic [255:0] ed;
    logic [31:0]  ek;

    pcs_ready_i = (stall_left == 0) && (rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1);
    if (stall_left > 0) stall_left--;
    valid = (src.size() > 0) && (src[0].pre == 0);
    if (valid) b = src[0];
    else begin
      b.data = {8{$urandom}};
      b.keep = '0;
      b.last = 1'b0;
      b.err  = 1'b0;
      b.pre  = 0;
    end
    sif.s_valid_i = valid;
    sif.s_data_i  = b.data;
    sif.s_keep_i  = b.keep;
    sif.s_last_i  = b.last;
    sif.s_err_i   = b.err;

    @(negedge clk);
    exp_rdy = nreset && pcs_ready_i && (in_frame || dropping || q.size() == 0);
    check("s_ready", 256'(sif.s_ready_o), 256'(exp_rdy));
    acc = exp_rdy && valid;
    if (!nreset) begin
      q.delete();
      in_frame = 1'b0;
      dropping = 1'b0;
      set_all(L_IDLE);
    end else if (pcs_ready_i) begin
      model_step(valid, acc, b);
    end

    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      ec[k] = cur[k].kind != L_DATA;
      ei[k] = cur[k].kind == L_IDLE;
      es[k] = cur[k].kind == L_START;
      et[k] = cur[k].kind == L_TERM;
      ee[k] = cur[k].kind == L_ERR;
      ed[k*64 +: 64] = (cur[k].kind == L_DATA || cur[k].kind == L_TERM) ? cur[k].data :
                       (cur[k].kind == L_START) ? START_WORD : 64'h0;
      ek[k*8 +: 8]   = (cur[k].kind == L_DATA || cur[k].kind == L_START) ? 8'hFF :
                       (cur[k].kind == L_TERM) ? cur[k].keep : 8'h00;
    end
    check("ctrl_v", 256'(ctrl_v_o), 256'(ec));
    check("idle_v", 256'(idle_v_o), 256'(ei));
    check("start_v", 256'(start_v_o), 256'(es));
    check("term_v", 256'(term_v_o), 256'(et));
    check("err_v", 256'(err_v_o), 256'(ee));
    check("data", data_o, ed);
    check("keep", 256'(keep_o), 256'(ek));

    if (acc) void'(src.pop_front());
    else if (src.size() > 0 && src[0].pre > 0) src[0].pre = src[0].pre - 1;
  endtask

  task automatic add_frame(input int unsigned len, input bit err, input int unsigned pre_first,
                           input int unsigned ur_beat);
    int unsigned nbeats, rem;
    beat_t b;
    nbeats = (len + 31) / 32;
    for (int unsigned i = 0; i < nbeats; i++) begin
      b.data = {8{$urandom}};
      b.last = (i == nbeats - 1);
      rem    = b.last ? len - 32 * i : 32;
      for (int unsigned j = 0; j < 32; j++) b.keep[j] = (j < rem);
      b.err  = b.last && err;
      b.pre  = (i == 0) ? pre_first : ((ur_beat != 0 && i == ur_beat) ? 1 : 0);
      src.push_back(b);
    end
  endtask

  task automatic drain(input int unsigned budget);
    logic done;
    done = 1'b0;
    for (int unsigned i = 0; i < budget; i++) begin
      done = (src.size() == 0) && (q.size() == 0) && !in_frame && !dropping;
      if (done) break;
      tick();
    end
    check("drain_done", 256'(done), 256'(1'b1));
    tick();
  endtask

  initial begin
    sif.s_valid_i = 1'b0;
    sif.s_data_i  = '0;
    sif.s_keep_i  = '0;
    sif.s_last_i  = 1'b0;
    sif.s_err_i   = 1'b0;
    set_all(L_IDLE);
    @(posedge clk);
    #1;
    repeat (3) tick();
    nreset = 1'b1;

    // Test-plan frames with the PCS always ready
    add_frame(64, 1'b0, 0, 0);
    add_frame(16, 1'b0, 0, 0);
    add_frame(60, 1'b0, 0, 0);
    add_frame(8, 1'b1, 0, 0);
    add_frame(1, 1'b0, 0, 0);
    add_frame(32, 1'b1, 0, 0);
    add_frame(31, 1'b0, 0, 0);
    drain(200);

    add_frame(128, 1'b0, 0, 0);
    tick();
    tick();
    stall_left = 3;
    drain(200);

    add_frame(96, 1'b0, 0, 1);
    drain(200);

    // Reset in the middle of a frame
    add_frame(100, 1'b0, 0, 0);
    tick();
    tick();
    nreset = 1'b0;
    tick();
    src.delete();
    nreset = 1'b1;
    drain(50);

    rand_rdy = 1'b1;
    for (int n = 0; n < 60; n++)
      add_frame($urandom_range(1, 160), ($urandom_range(0, 7) == 0), $urandom_range(0, 2),
                ($urandom_range(0, 5) == 0) ? $urandom_range(1, 4) : 0);
    drain(20000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
